fpu_result_collector: RTL
=========================

# fpu_result_collector

Drain end of the FPU datapath pipeline. Tracks which `float_point_num` entries in the `STAGES`-deep `en`-gated pipeline hold valid results, captures the tail result into a small output FIFO, and presents it downstream with a valid/ready handshake. When the FIFO cannot take the tail result, it stalls the pipeline and the upstream issuer by dropping `pipe_en`. It is the consumer-side counterpart of the pipeline register chain and the only source of that chain's `en`.

## Interface
Parameters:
- `STAGES`, 6: pipeline depth being tracked; must match the pipeline register chain; ≥1.
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-low (asserted when 0).
- `in_valid` in 1: upstream issues an operation into pipeline stage 0 this cycle.
- `in_ready` out 1: issue accepted; equals `pipe_en`.
- `pipe_en` out 1: enable for the pipeline register chain.
- `tail_data` in `float_point_num`: pipeline last-stage output (`out_data[STAGES-1]`).
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts head.
- `out_data` out `float_point_num`: FIFO head.
- `occupancy` out `$clog2(DEPTH)+1`: FIFO entry count, 0..DEPTH.
- `in_flight` out `$clog2(STAGES)+1`: number of set valid bits in the tracker.

## Operation
- Valid tracker `vld[0:STAGES-1]` shadows the pipeline. When `pipe_en`=1: `vld[0]<=in_valid`, `vld[i]<=vld[i-1]`. When `pipe_en`=0: hold.
- The tail is valid when `vld[STAGES-1]`=1.
- `pop = out_valid & out_ready`.
- `pipe_en = ~vld[STAGES-1] | (occupancy < DEPTH) | pop`. This is combinational and depends on `out_ready` in the same cycle. A full FIFO with a simultaneous pop does not stall.
- `push = vld[STAGES-1] & pipe_en`. This writes `tail_data` at the FIFO tail.
- Push and pop in the same cycle leave `occupancy` unchanged. This holds at 0 (pop impossible, so only push) and at DEPTH (push needs pop).
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is tracked separately, so full and empty are unambiguous.
- `in_flight` is updated incrementally: +`in_valid`&`pipe_en`, −`push`. It never exceeds STAGES.
- The FIFO is first-word-fall-through: `out_data` = `mem[rd_ptr]`, and `out_valid` = `occupancy != 0`.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Data is dropped only on reset. No result is lost or duplicated under any `out_ready` pattern.

## Timing
- Reset (rst=0 at an edge) clears `vld`, pointers, `occupancy`, and `in_flight`.
- Values in the cycle after reset: `out_valid`=0, `occupancy`=0, `in_flight`=0, `pipe_en`=`in_ready`=1.
- FIFO memory and `out_data` contents are not reset and are don't-care while `out_valid`=0.
- Reset mid-operation discards all in-flight and queued results. The pipeline data registers themselves need not be cleared, since `vld` gates everything.
- Latency with `out_ready` held at 1: a result issued at edge N is at the tail after edge N+STAGES−1, is pushed at edge N+STAGES, and shows `out_valid`=1 in the following cycle.
- Throughput with `out_ready`=1: one result per cycle, with no bubbles.
- Stall: with the FIFO full, the tail valid and `out_ready`=0, `pipe_en`=0 and the whole pipeline freezes. It releases in the same cycle `out_ready` rises.

## Structure
- `DEPTH` constraints and the `float_point_num` typedef live in the shared `float_struct` package. `float_point_num` is a 32-bit packed {sign, exp[7:0], mant[22:0]}.
- Add a package function `clog2_min1` for pointer widths with DEPTH/STAGES = 1.
- Natural sub-module: `fpu_result_fifo` (FWFT, parameter `DEPTH`, push/pop/count). The collector owns the valid tracker and the `pipe_en` logic.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 → `out_valid`=0, `occupancy`=0, `in_flight`=0, `pipe_en`=1 after release.
- Latency: STAGES=6, issue one op at edge 0 with tail model returning 0x3F800000 → `out_valid`=1 first seen in the cycle after edge 6 with `out_data`=0x3F800000; `occupancy`=1.
- Streaming: 20 back-to-back issues with `out_ready`=1 → 20 results in order, contiguous `out_valid`, `pipe_en` never 0.
- Backpressure: `out_ready`=0 with continuous issue → `occupancy` reaches 4, `pipe_en`=0 once the tail is valid, `in_flight`=6. Then `out_ready`=1 → all 10 results drain in order with no loss.
- Full plus simultaneous pop: FIFO full, tail valid, `out_ready`=1 for one cycle → `pipe_en`=1 that cycle, `occupancy` stays 4, new tail value appended.
- Reset mid-operation: reset with 3 entries queued and 5 in flight → all counts 0; no stale result appears afterwards.

Source files
------------

// File: rtl/float_struct.sv
// Shared FPU number format and sizing helpers for the result drain logic.
package float_struct;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  // FIFO depth must be a power of two and at least 2 so pointers wrap naturally.
  // Widths for 1-entry structures still need one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// First-word-fall-through result FIFO with an explicit entry count.
module fpu_result_fifo
  import float_struct::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  float_point_num         wr_data,
  input  logic                   pop,
  output float_point_num         rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = clog2_min1(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  float_point_num  mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en, rd_en;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fpu_result_collector.sv
// Drain end of the FPU pipeline: valid tracking, pipeline enable and output buffering.
module fpu_result_collector
  import float_struct::*;
#(
  parameter int unsigned STAGES = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    pipe_en,
  input  float_point_num          tail_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output float_point_num          out_data,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [$clog2(STAGES):0] in_flight
);

  localparam int unsigned FlW = $clog2(STAGES) + 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [FlW-1:0]    in_flight_q, in_flight_d;
  logic              tail_vld;
  logic              fifo_full, fifo_empty;
  logic              push, pop, issue;

  assign tail_vld = vld_q[STAGES-1];
  assign pop      = out_valid & out_ready;
  // Stall only when the tail result has nowhere to go this cycle.
  assign pipe_en  = ~tail_vld | ~fifo_full | pop;
  assign in_ready = pipe_en;
  assign push     = tail_vld & pipe_en;
  assign issue    = in_valid & pipe_en;

  always_comb begin
    vld_d       = vld_q;
    in_flight_d = in_flight_q + FlW'(issue) - FlW'(push);
    if (pipe_en) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < STAGES; i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q       <= '0;
      in_flight_q <= '0;
    end else begin
      vld_q       <= vld_d;
      in_flight_q <= in_flight_d;
    end
  end

  fpu_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (tail_data),
    .pop     (pop),
    .rd_data (out_data),
    .count   (occupancy),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign in_flight = in_flight_q;

endmodule
